// File: rtl/alu_seq_pkg.sv
// Shared opcode, FSM state and flag-index definitions for alu_seq.
// Opcode encodings track the picoMIPS decoder so existing microcode keeps working.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    F_B     = 4'd0,
    F_ADD   = 4'd1,
    F_SUB   = 4'd2,
    F_MUL   = 4'd3,
    F_LSW   = 4'd4,
    F_MOVSW = 4'd5
  } func_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  localparam int FLAG_V = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

endpackage

// File: rtl/alu_seq_mulstep.sv
// Iterative unsigned shift-add multiplier: one adder, N partial-product steps.
// Latency N edges from start; done is high during the final step, product is final the cycle after.
module alu_seq_mulstep
  import alu_seq_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic [2*N-1:0] product,
  output logic           done
);

  localparam int CW = $clog2(N) + 1;

  logic [N-1:0]   mcand;
  logic [N-1:0]   mplier;
  logic [2*N-1:0] acc;
  logic [CW-1:0]  cnt;

  logic [N-1:0]   addend;
  logic [N:0]     sum;
  logic [N-1:0]   first_pp;
  logic [2*N-1:0] acc_step;
  logic [2*N-1:0] acc_first;

  assign addend    = mplier[0] ? mcand : '0;
  assign sum       = {1'b0, acc[2*N-1:N]} + {1'b0, addend};
  assign acc_step  = {sum, acc[N-1:1]};
  // The first partial product is folded into the load edge, so N-1 steps remain.
  assign first_pp  = multiplier[0] ? multiplicand : '0;
  assign acc_first = {1'b0, first_pp, {(N-1){1'b0}}};

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (start) begin
      mcand  <= multiplicand;
      mplier <= multiplier >> 1;
      acc    <= acc_first;
      cnt    <= CW'(N - 1);
    end else if (cnt != '0) begin
      acc    <= acc_step;
      mplier <= mplier >> 1;
      cnt    <= cnt - 1'b1;
    end
  end

  assign product = acc;
  assign done    = (cnt == CW'(1));

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle ops finish 1 cycle after accept, signed fractional MUL after N+1.
// in_ready is low while a MUL is in flight; requests offered then are simply not accepted.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int N    = 8,
  parameter int FRAC = N - 1,
  parameter int SAT  = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   func,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] sw,
  input  logic         sw_bit,
  output logic         out_valid,
  output logic [N-1:0] result,
  output logic [3:0]   flags
);

  state_t state, state_nxt;

  logic           accept, mul_start, mul_done, upd;
  logic           mul_sign;
  logic [N-1:0]   abs_a, abs_b;
  logic [2*N-1:0] mul_product, prod_s;
  logic [N-1:0]   mul_res;
  logic           mul_v, mul_neg;
  logic [N:0]     add_sum, sub_sum;
  logic [N-1:0]   sc_res, pre_res, fin_res;
  logic           sc_v, sc_c, sc_neg;
  logic           pre_v, pre_c, pre_neg;
  logic [3:0]     flags_nxt;

  assign in_ready  = (state == S_IDLE);
  assign accept    = in_valid & in_ready;
  assign mul_start = accept && (func == F_MUL);
  assign upd       = (accept && (func != F_MUL)) || (state == S_FIX);

  assign abs_a = a[N-1] ? -a : a;
  assign abs_b = b[N-1] ? -b : b;

  alu_seq_mulstep #(.N(N)) u_mulstep (
    .clk          (clk),
    .reset        (reset),
    .start        (mul_start),
    .multiplicand (abs_a),
    .multiplier   (abs_b),
    .product      (mul_product),
    .done         (mul_done)
  );

  assign prod_s  = mul_sign ? -mul_product : mul_product;
  assign mul_res = prod_s[FRAC+N-1:FRAC];
  assign mul_neg = prod_s[2*N-1];

  // Overflow when the bits above the slice are not a sign extension of it.
  generate
    if (FRAC < N) begin : g_mul_hi
      assign mul_v = (prod_s[2*N-1:FRAC+N] != {(N-FRAC){mul_res[N-1]}});
    end else begin : g_mul_nohi
      assign mul_v = 1'b0;
    end
    if (FRAC > 0) begin : g_unused_lo
      logic unused_lo;
      assign unused_lo = ^{prod_s[FRAC-1:0], sw[N-1]};
    end else begin : g_unused_sw
      logic unused_sw;
      assign unused_sw = sw[N-1];
    end
  endgenerate

  assign add_sum = {1'b0, a} + {1'b0, b};
  assign sub_sum = {1'b0, b} + {1'b0, ~a} + {{N{1'b0}}, 1'b1};

  always_comb begin
    sc_res = '0;
    sc_v   = 1'b0;
    sc_c   = 1'b0;
    sc_neg = 1'b0;
    case (func)
      F_B:     sc_res = b;
      F_ADD: begin
        sc_res = add_sum[N-1:0];
        sc_c   = add_sum[N];
        sc_v   = (a[N-1] == b[N-1]) && (add_sum[N-1] != a[N-1]);
        sc_neg = a[N-1];
      end
      F_SUB: begin
        sc_res = sub_sum[N-1:0];
        sc_c   = sub_sum[N];
        sc_v   = (a[N-1] != b[N-1]) && (sub_sum[N-1] != b[N-1]);
        sc_neg = b[N-1];
      end
      F_LSW:   sc_res = {{(N-1){1'b0}}, sw_bit};
      F_MOVSW: sc_res = {1'b0, sw[N-2:0]};
      default: sc_res = '0;
    endcase
  end

  always_comb begin
    pre_res = sc_res;
    pre_v   = sc_v;
    pre_c   = sc_c;
    pre_neg = sc_neg;
    if (state == S_FIX) begin
      pre_res = mul_res;
      pre_v   = mul_v;
      pre_c   = 1'b0;
      pre_neg = mul_neg;
    end
    fin_res = pre_res;
    // pre_neg is the sign of the true (unwrapped) value, which picks the clamp rail.
    if ((SAT != 0) && pre_v) begin
      fin_res = pre_neg ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end
    flags_nxt         = '0;
    flags_nxt[FLAG_V] = pre_v;
    flags_nxt[FLAG_N] = fin_res[N-1];
    flags_nxt[FLAG_Z] = (fin_res == '0);
    flags_nxt[FLAG_C] = pre_c;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (mul_start) state_nxt = S_MUL;
      S_MUL:   if (mul_done) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      result    <= '0;
      flags     <= '0;
      out_valid <= 1'b0;
      mul_sign  <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_valid <= upd;
      if (mul_start) mul_sign <= a[N-1] ^ b[N-1];
      if (upd) begin
        result <= fin_res;
        flags  <= flags_nxt;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: three instances (N=8 wrap, N=8 saturating, N=16 wrap).
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        iv8 = 1'b0, iv16 = 1'b0, sw_bit = 1'b0;
  logic [3:0]  func = 4'd0;
  logic [7:0]  a8 = '0, b8 = '0, sw8 = '0;
  logic [15:0] a16 = '0, b16 = '0, sw16 = '0;

  logic        r8_rdy, r8_ov, s8_rdy, s8_ov, r16_rdy, r16_ov;
  logic [7:0]  r8_res, s8_res;
  logic [15:0] r16_res;
  logic [3:0]  r8_fl, s8_fl, r16_fl;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_seq #(.N(8), .FRAC(7), .SAT(0)) u8 (
    .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(r8_rdy), .func(func),
    .a(a8), .b(b8), .sw(sw8), .sw_bit(sw_bit),
    .out_valid(r8_ov), .result(r8_res), .flags(r8_fl));

  alu_seq #(.N(8), .FRAC(7), .SAT(1)) u8s (
    .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(s8_rdy), .func(func),
    .a(a8), .b(b8), .sw(sw8), .sw_bit(sw_bit),
    .out_valid(s8_ov), .result(s8_res), .flags(s8_fl));

  alu_seq #(.N(16), .FRAC(15), .SAT(0)) u16 (
    .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(r16_rdy), .func(func),
    .a(a16), .b(b16), .sw(sw16), .sw_bit(sw_bit),
    .out_valid(r16_ov), .result(r16_res), .flags(r16_fl));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one op to both N=8 instances; returns in cycle 1 after the accept edge.
  task automatic do_op8(input logic [3:0] f, input logic [7:0] av, input logic [7:0] bv);
    func = f; a8 = av; b8 = bv; iv8 = 1'b1;
    tick;
    iv8 = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick; tick;
    total++; if (r8_rdy !== 1'b1 || r16_rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy got=%b/%b want=1/1", r8_rdy, r16_rdy); end
    total++; if (r8_ov !== 1'b0 || r8_res !== 8'h00 || r8_fl !== 4'h0) begin bad++; $display("FAIL reset_u8 ov=%b res=%h fl=%b want 0/00/0000", r8_ov, r8_res, r8_fl); end
    total++; if (r16_ov !== 1'b0 || r16_res !== 16'h0 || r16_fl !== 4'h0) begin bad++; $display("FAIL reset_u16 ov=%b res=%h fl=%b want 0/0000/0000", r16_ov, r16_res, r16_fl); end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_add;
    do_op8(F_ADD, 8'h70, 8'h20);
    total++; if (r8_ov !== 1'b1 || r8_res !== 8'h90 || r8_fl !== 4'b1100) begin bad++; $display("FAIL add_wrap ov=%b res=%h fl=%b want 1/90/1100", r8_ov, r8_res, r8_fl); end
    total++; if (s8_res !== 8'h7F || s8_fl !== 4'b1000) begin bad++; $display("FAIL add_sat res=%h fl=%b want 7f/1000", s8_res, s8_fl); end
    tick;
    total++; if (r8_ov !== 1'b0 || r8_res !== 8'h90) begin bad++; $display("FAIL add_pulse ov=%b res=%h want 0/90", r8_ov, r8_res); end
  endtask

  task automatic test_sub;
    do_op8(F_SUB, 8'h05, 8'h05);
    total++; if (r8_res !== 8'h00 || r8_fl !== 4'b0011) begin bad++; $display("FAIL sub_zero res=%h fl=%b want 00/0011", r8_res, r8_fl); end
    do_op8(F_SUB, 8'h06, 8'h05);
    total++; if (r8_res !== 8'hFF || r8_fl !== 4'b0100) begin bad++; $display("FAIL sub_borrow res=%h fl=%b want ff/0100", r8_res, r8_fl); end
  endtask

  task automatic test_moves;
    do_op8(F_B, 8'h33, 8'hA5);
    total++; if (r8_res !== 8'hA5 || r8_fl !== 4'b0100) begin bad++; $display("FAIL op_b res=%h fl=%b want a5/0100", r8_res, r8_fl); end
    sw_bit = 1'b1;
    do_op8(F_LSW, 8'hFF, 8'hFF);
    total++; if (r8_res !== 8'h01 || r8_fl !== 4'b0000) begin bad++; $display("FAIL op_lsw res=%h fl=%b want 01/0000", r8_res, r8_fl); end
    sw8 = 8'hFF;
    do_op8(F_MOVSW, 8'h00, 8'h00);
    total++; if (r8_res !== 8'h7F || r8_fl !== 4'b0000) begin bad++; $display("FAIL op_movsw res=%h fl=%b want 7f/0000", r8_res, r8_fl); end
    do_op8(4'hF, 8'h12, 8'h34);
    total++; if (r8_ov !== 1'b1 || r8_res !== 8'h00 || r8_fl !== 4'b0010) begin bad++; $display("FAIL op_undef ov=%b res=%h fl=%b want 1/00/0010", r8_ov, r8_res, r8_fl); end
    tick;
  endtask

  task automatic test_mul;
    do_op8(F_MUL, 8'h40, 8'h40);
    a8 = 8'h00; b8 = 8'h00;
    for (int i = 1; i <= 8; i++) begin
      total++; if (r8_rdy !== 1'b0 || r8_ov !== 1'b0) begin bad++; $display("FAIL mul_busy cyc=%0d rdy=%b ov=%b want 0/0", i, r8_rdy, r8_ov); end
      tick;
    end
    total++; if (r8_ov !== 1'b1 || r8_rdy !== 1'b1) begin bad++; $display("FAIL mul_done_c9 ov=%b rdy=%b want 1/1", r8_ov, r8_rdy); end
    total++; if (r8_res !== 8'h20 || r8_fl !== 4'b0000) begin bad++; $display("FAIL mul_half res=%h fl=%b want 20/0000", r8_res, r8_fl); end
    tick;
    total++; if (r8_ov !== 1'b0) begin bad++; $display("FAIL mul_pulse ov=%b want 0", r8_ov); end

    do_op8(F_MUL, 8'hC0, 8'h40);
    repeat (8) tick;
    total++; if (r8_res !== 8'hE0 || r8_fl !== 4'b0100) begin bad++; $display("FAIL mul_neg res=%h fl=%b want e0/0100", r8_res, r8_fl); end

    do_op8(F_MUL, 8'h80, 8'h80);
    repeat (8) tick;
    total++; if (r8_res !== 8'h80 || r8_fl !== 4'b1100) begin bad++; $display("FAIL mul_ovf_wrap res=%h fl=%b want 80/1100", r8_res, r8_fl); end
    total++; if (s8_ov !== 1'b1 || s8_res !== 8'h7F || s8_fl !== 4'b1000) begin bad++; $display("FAIL mul_ovf_sat ov=%b res=%h fl=%b want 1/7f/1000", s8_ov, s8_res, s8_fl); end
    tick;
  endtask

  task automatic test_busy_drop;
    int cyc;
    do_op8(F_MUL, 8'h40, 8'h40);
    tick;
    func = F_B; b8 = 8'h11; iv8 = 1'b1;
    tick;
    iv8 = 1'b0;
    cyc = 3;
    while (r8_ov !== 1'b1 && cyc < 30) begin
      tick;
      cyc++;
    end
    total++; if (cyc != 9) begin bad++; $display("FAIL drop_timing out_valid_cycle=%0d want 9", cyc); end
    total++; if (r8_res !== 8'h20) begin bad++; $display("FAIL drop_result res=%h want 20", r8_res); end
    tick;
    total++; if (r8_ov !== 1'b0 || r8_res !== 8'h20) begin bad++; $display("FAIL drop_no_extra ov=%b res=%h want 0/20", r8_ov, r8_res); end
  endtask

  task automatic test_reset_mid_mul;
    do_op8(F_MUL, 8'h40, 8'h40);
    tick; tick; tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    total++; if (r8_rdy !== 1'b1 || r8_ov !== 1'b0) begin bad++; $display("FAIL abort_hs rdy=%b ov=%b want 1/0", r8_rdy, r8_ov); end
    total++; if (r8_res !== 8'h00 || r8_fl !== 4'b0000) begin bad++; $display("FAIL abort_state res=%h fl=%b want 00/0000", r8_res, r8_fl); end
    repeat (10) begin
      tick;
      total++; if (r8_ov !== 1'b0) begin bad++; $display("FAIL abort_ghost ov=%b want 0", r8_ov); end
    end
  endtask

  task automatic test_back_to_back;
    func = F_MUL; a16 = 16'h4000; b16 = 16'h4000; iv16 = 1'b1;
    tick;
    iv16 = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      total++; if (r16_rdy !== 1'b0 || r16_ov !== 1'b0) begin bad++; $display("FAIL mul16_busy cyc=%0d rdy=%b ov=%b want 0/0", i, r16_rdy, r16_ov); end
      tick;
    end
    total++; if (r16_ov !== 1'b1 || r16_res !== 16'h2000 || r16_fl !== 4'b0000) begin bad++; $display("FAIL mul16_c17 ov=%b res=%h fl=%b want 1/2000/0000", r16_ov, r16_res, r16_fl); end
    func = F_ADD; a16 = 16'h0001; b16 = 16'h0002; iv16 = 1'b1;
    tick;
    iv16 = 1'b0;
    total++; if (r16_ov !== 1'b1 || r16_res !== 16'h0003 || r16_fl !== 4'b0000) begin bad++; $display("FAIL b2b_add ov=%b res=%h fl=%b want 1/0003/0000", r16_ov, r16_res, r16_fl); end
    tick;
    total++; if (r16_ov !== 1'b0) begin bad++; $display("FAIL b2b_pulse ov=%b want 0", r16_ov); end
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_moves;
    test_mul;
    test_busy_drop;
    test_reset_mid_mul;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
